// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: in-order instruction fetch with a small response queue.
// Requests carry a credit so that allocated entries plus responses still owed
// to a flushed fetch never exceed DEPTH. Redirects flush the queue and count
// the responses that must still be discarded.
module rv32i_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW:0]   W_DEPTH = DEPTH[CW:0];

   logic [31:0]      r_pc;
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [AW-1:0]    r_fill_ptr;
   logic [CW-1:0]    r_alloc_cnt;
   logic [CW-1:0]    r_unfilled_cnt;
   logic [CW-1:0]    r_drop_cnt;
   logic [31:0]      r_q_pc   [DEPTH];
   logic [31:0]      r_q_data [DEPTH];
   logic [DEPTH-1:0] r_q_filled;

   logic [CW:0] w_inflight;
   logic        w_req_valid;
   logic        w_req_fire;
   logic        w_dec_valid;
   logic        w_pop;
   logic        w_fill;
   logic        w_drop_rsp;

   // Credit, handshake and queue-event decode from current state and inputs.
   always_comb begin
      w_inflight  = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt};
      w_req_valid = !rst && !redirect && (w_inflight < W_DEPTH);
      w_req_fire  = w_req_valid && imem_req_ready;
      w_dec_valid = (r_alloc_cnt != '0) && r_q_filled[r_head] && !redirect;
      w_pop       = w_dec_valid && dec_ready;
      w_drop_rsp  = imem_rsp_valid && (r_drop_cnt != '0);
      w_fill      = imem_rsp_valid && (r_drop_cnt == '0) && !redirect;
   end

   // Control state: PC, queue pointers, occupancy and drop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc           <= RESET_PC;
         r_head         <= '0;
         r_tail         <= '0;
         r_fill_ptr     <= '0;
         r_alloc_cnt    <= '0;
         r_unfilled_cnt <= '0;
         r_drop_cnt     <= '0;
         r_q_filled     <= '0;
      end else if (redirect) begin
         // A response arriving now pays off one owed response first.
         r_pc           <= {redirect_pc[31:2], 2'b00};
         r_head         <= '0;
         r_tail         <= '0;
         r_fill_ptr     <= '0;
         r_alloc_cnt    <= '0;
         r_unfilled_cnt <= '0;
         r_drop_cnt     <= r_drop_cnt + r_unfilled_cnt - CW'(imem_rsp_valid);
         r_q_filled     <= '0;
      end else begin
         if (w_req_fire) begin
            r_pc               <= r_pc + 32'd4;
            r_tail             <= r_tail + PTR_ONE;
            r_q_filled[r_tail] <= 1'b0;
         end
         if (w_pop) begin
            r_head <= r_head + PTR_ONE;
         end
         if (w_fill) begin
            r_fill_ptr             <= r_fill_ptr + PTR_ONE;
            r_q_filled[r_fill_ptr] <= 1'b1;
         end
         r_alloc_cnt    <= r_alloc_cnt + CW'(w_req_fire) - CW'(w_pop);
         r_unfilled_cnt <= r_unfilled_cnt + CW'(w_req_fire) - CW'(w_fill);
         r_drop_cnt     <= r_drop_cnt - CW'(w_drop_rsp);
      end
   end

   // Queue payload: PC captured at request, instruction word at fill.
   always_ff @(posedge clk) begin
      if (w_req_fire) begin
         r_q_pc[r_tail] <= r_pc;
      end
      if (w_fill) begin
         r_q_data[r_fill_ptr] <= imem_rsp_data;
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;
   assign dec_valid      = w_dec_valid;
   assign dec_inst       = w_dec_valid ? r_q_data[r_head] : NOP_INST;
   assign dec_pc         = w_dec_valid ? r_q_pc[r_head] : 32'h0000_0000;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with an in-order instruction memory
// model whose responses can be held off to create in-flight fetches.
module tb_rv32i_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        dec_valid;
   logic        dec_ready = 1'b1;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;

   logic        rsp_en = 1'b1;
   logic [31:0] pend [$];
   logic [31:0] exp_req = 32'h0;
   logic [31:0] exp_dec = 32'h0;
   int          n_req = 0;
   int          n_vec = 0;
   int          n_err = 0;

   rv32i_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_inst       (dec_inst),
      .dec_pc         (dec_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory model: one-cycle minimum latency, in order, gated by rsp_en.
   always @(posedge clk) begin
      if (rst) begin
         pend.delete();
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= 32'h0;
      end else begin
         if (imem_rsp_valid) pend.delete(0);
         if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
         if (rsp_en && pend.size() > 0) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= word(pend[0]);
         end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'hDEAD_BEEF;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Run n cycles, checking every request address and every delivered instruction in order.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            n_req++;
         end
         if (dec_valid && dec_ready) begin
            chk("dec_pc", dec_pc, exp_dec);
            chk("dec_inst", dec_inst, word(exp_dec));
            exp_dec = exp_dec + 32'd4;
         end
         step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      step();
      step();
      rst = 1'b0;
      n_req = 0;
   endtask

   initial begin
      // Reset values
      step();
      step();
      settle();
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
      chk1("rst_dec_valid", dec_valid, 1'b0);
      chk("rst_dec_inst", dec_inst, 32'h0000_0013);
      chk("rst_dec_pc", dec_pc, 32'h0000_0000);
      step();
      rst = 1'b0;

      // Streaming fetch, first word two cycles after first handshake
      settle();
      chk1("t1_req0_valid", imem_req_valid, 1'b1);
      chk("t1_req0_addr", imem_req_addr, 32'h0000_0000);
      chk1("t1_c0_dec_valid", dec_valid, 1'b0);
      step();
      settle();
      chk1("t1_req1_valid", imem_req_valid, 1'b1);
      chk("t1_req1_addr", imem_req_addr, 32'h0000_0004);
      chk1("t1_c1_dec_valid", dec_valid, 1'b0);
      step();
      settle();
      chk1("t1_c2_dec_valid", dec_valid, 1'b1);
      chk("t1_c2_dec_pc", dec_pc, 32'h0000_0000);
      chk("t1_c2_dec_inst", dec_inst, 32'hC0DE_0000);
      chk1("t1_c2_full", imem_req_valid, 1'b0);
      step();
      exp_req = 32'h0000_0008;
      exp_dec = 32'h0000_0004;
      run(12);
      chk("t1_dec_progress", exp_dec, 32'h0000_0024);
      chk("t1_req_progress", exp_req, 32'h0000_0028);

      // Decode stall: exactly DEPTH requests, output held
      do_reset();
      dec_ready = 1'b0;
      exp_req = 32'h0;
      exp_dec = 32'h0;
      run(6);
      chk("t2_nreq", n_req, 32'd2);
      settle();
      chk1("t2_req_valid", imem_req_valid, 1'b0);
      chk1("t2_dec_valid", dec_valid, 1'b1);
      chk("t2_dec_pc", dec_pc, 32'h0000_0000);
      chk("t2_dec_inst", dec_inst, 32'hC0DE_0000);
      step();
      dec_ready = 1'b1;
      run(6);
      chk("t2_dec_progress", exp_dec, 32'h0000_0010);
      chk("t2_req_progress", exp_req, 32'h0000_0018);

      // Redirect with two unanswered requests in flight
      do_reset();
      rsp_en = 1'b0;
      exp_req = 32'h0;
      exp_dec = 32'h0;
      run(3);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      settle();
      chk1("t3_redir_req_valid", imem_req_valid, 1'b0);
      chk1("t3_redir_dec_valid", dec_valid, 1'b0);
      step();
      redirect = 1'b0;
      rsp_en = 1'b1;
      exp_req = 32'h0000_0100;
      exp_dec = 32'h0000_0100;
      run(10);
      chk("t3_dec_progress", exp_dec, 32'h0000_0110);
      chk("t3_req_progress", exp_req, 32'h0000_0118);

      // Redirect in the same cycle as a response, one other entry unfilled
      do_reset();
      rsp_en = 1'b0;
      exp_req = 32'h0;
      exp_dec = 32'h0;
      run(2);
      rsp_en = 1'b1;
      run(1);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      settle();
      chk1("t4_redir_req_valid", imem_req_valid, 1'b0);
      step();
      redirect = 1'b0;
      exp_req = 32'h0000_0200;
      exp_dec = 32'h0000_0200;
      settle();
      chk1("t4_credit", imem_req_valid, 1'b1);
      run(6);
      chk("t4_dec_progress", exp_dec, 32'h0000_020C);
      chk("t4_req_progress", exp_req, 32'h0000_0210);

      // Memory not ready: address held, PC not advanced
      do_reset();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk1("t5_hold_valid", imem_req_valid, 1'b1);
         chk("t5_hold_addr", imem_req_addr, 32'h0000_0000);
         step();
      end
      imem_req_ready = 1'b1;
      exp_req = 32'h0;
      exp_dec = 32'h0;
      run(8);
      chk("t5_dec_progress", exp_dec, 32'h0000_0010);
      chk("t5_req_progress", exp_req, 32'h0000_0018);

      // Reset with a full queue and a valid instruction presented
      do_reset();
      dec_ready = 1'b0;
      exp_req = 32'h0;
      exp_dec = 32'h0;
      run(4);
      rst = 1'b1;
      settle();
      chk1("t6_pre_dec_valid", dec_valid, 1'b1);
      chk1("t6_rst_req_valid", imem_req_valid, 1'b0);
      step();
      settle();
      chk1("t6_dec_valid", dec_valid, 1'b0);
      chk("t6_dec_inst", dec_inst, 32'h0000_0013);
      chk("t6_req_addr", imem_req_addr, 32'h0000_0000);
      chk("t6_dec_pc", dec_pc, 32'h0000_0000);
      step();
      rst = 1'b0;
      dec_ready = 1'b1;
      exp_req = 32'h0;
      exp_dec = 32'h0;
      run(4);
      chk("t6_dec_progress", exp_dec, 32'h0000_0008);
      chk("t6_req_progress", exp_req, 32'h0000_000C);

      // Redirect masks a valid head instruction
      do_reset();
      dec_ready = 1'b0;
      exp_req = 32'h0;
      exp_dec = 32'h0;
      run(4);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0041;
      settle();
      chk1("t7_redir_dec_valid", dec_valid, 1'b0);
      chk("t7_redir_dec_inst", dec_inst, 32'h0000_0013);
      chk1("t7_redir_req_valid", imem_req_valid, 1'b0);
      step();
      redirect = 1'b0;
      dec_ready = 1'b1;
      exp_req = 32'h0000_0040;
      exp_dec = 32'h0000_0040;
      run(6);
      chk("t7_dec_progress", exp_dec, 32'h0000_004C);
      chk("t7_req_progress", exp_req, 32'h0000_0050);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
